// File: rtl/io_monitor_pkg.sv
// ---------------------------------------------------------------------------
// io_monitor_pkg : shared addresses, state encoding and byte type for io_monitor
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package io_monitor_pkg;

  localparam logic [31:0] IO_CHAR_ADDR_DEF = 32'h0003_0000;
  localparam logic [31:0] IO_HALT_ADDR_DEF = 32'h0003_0004;

  typedef logic [7:0] byte_t;

  localparam byte_t TIMEOUT_EXIT_CODE = 8'hFF;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/io_char_fifo.sv
// ---------------------------------------------------------------------------
// io_char_fifo : synchronous first-word-fall-through FIFO with wrap-bit pointers
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module io_char_fifo #(
  parameter int DEPTH_LOG = 4,
  parameter int W         = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] data
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] PTR_ONE = {{DEPTH_LOG{1'b0}}, 1'b1};

  logic [DEPTH_LOG:0] wr_ptr;
  logic [DEPTH_LOG:0] rd_ptr;
  logic [W-1:0]       mem [DEPTH];
  logic [W-1:0]       last_data;
  logic               do_push;
  logic               do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[DEPTH_LOG] != rd_ptr[DEPTH_LOG]) &&
                   (wr_ptr[DEPTH_LOG-1:0] == rd_ptr[DEPTH_LOG-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push on full is still taken.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      last_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        last_data <= mem[rd_ptr[DEPTH_LOG-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[DEPTH_LOG-1:0]] <= push_data;
  end

  // When empty the output keeps showing the most recently drained byte.
  assign data = empty ? last_data : mem[rd_ptr[DEPTH_LOG-1:0]];

endmodule

`default_nettype wire

// File: rtl/io_monitor.sv
// ---------------------------------------------------------------------------
// io_monitor : bus snooper for character output and program-halt detection.
// Optional watchdog enabled by IO_MONITOR_TIMEOUT_EN.  Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module io_monitor
  import io_monitor_pkg::*;
#(
  parameter int                FIFO_DEPTH_LOG = 4,
  parameter int                ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] IO_CHAR_ADDR   = IO_CHAR_ADDR_DEF[ADDR_W-1:0],
  parameter logic [ADDR_W-1:0] IO_HALT_ADDR   = IO_HALT_ADDR_DEF[ADDR_W-1:0]
`ifdef IO_MONITOR_TIMEOUT_EN
  ,
  parameter logic [31:0]       TIMEOUT_CYCLES = 32'd50_000_000
`endif
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [ADDR_W-1:0] mem_a,
  input  logic [7:0]        mem_dout,
  input  logic              mem_wr,
  output logic              char_valid,
  output logic [7:0]        char_data,
  input  logic              char_ready,
  output logic              done,
  output logic [7:0]        exit_code,
  output logic [31:0]       cycle_count,
  output logic              overflow
`ifdef IO_MONITOR_TIMEOUT_EN
  ,
  output logic              timeout
`endif
);

  state_t      state;
  state_t      state_next;
  logic        in_run;
  logic        bus_char;
  logic        bus_halt;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic        tmo_hit;
  logic [31:0] count_inc;

  assign in_run    = (state == ST_RUN);
  assign bus_char  = in_run & rdy_in & mem_wr & (mem_a == IO_CHAR_ADDR);
  assign bus_halt  = in_run & rdy_in & mem_wr & (mem_a == IO_HALT_ADDR);
  assign pop       = char_valid & char_ready;
  assign char_valid = ~fifo_empty;
  assign count_inc = (cycle_count == 32'hFFFF_FFFF) ? cycle_count : cycle_count + 32'd1;

`ifdef IO_MONITOR_TIMEOUT_EN
  assign tmo_hit = in_run & rdy_in & ~bus_halt & (count_inc >= TIMEOUT_CYCLES);
`else
  assign tmo_hit = 1'b0;
`endif

  io_char_fifo #(
    .DEPTH_LOG (FIFO_DEPTH_LOG),
    .W         (8)
  ) u_fifo (
    .clk       (clk_in),
    .rst       (rst_in),
    .push      (bus_char),
    .push_data (mem_dout),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .data      (char_data)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= ST_RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:   if (bus_halt || tmo_hit) state_next = ST_DRAIN;
      ST_DRAIN: if (rdy_in && fifo_empty) state_next = ST_DONE;
      ST_DONE:  state_next = ST_DONE;
      default:  state_next = ST_RUN;
    endcase
  end

  always_comb begin
    done = (state == ST_DONE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cycle_count <= '0;
      exit_code   <= '0;
      overflow    <= 1'b0;
    end else begin
      if (in_run && rdy_in) cycle_count <= count_inc;
      if (bus_halt) exit_code <= mem_dout;
      else if (tmo_hit) exit_code <= TIMEOUT_EXIT_CODE;
      if (bus_char && fifo_full && !pop) overflow <= 1'b1;
    end
  end

`ifdef IO_MONITOR_TIMEOUT_EN
  always_ff @(posedge clk_in) begin
    if (rst_in)       timeout <= 1'b0;
    else if (tmo_hit) timeout <= 1'b1;
  end
`endif

endmodule

`default_nettype wire

// File: doc/io_monitor.md
Name: io_monitor

Overview:
- Simulation-side consumer of the CPU memory bus, one stage downstream of the CPU's I/O writes; replaces reliance on UART/HCI round-trip for end-of-test detection.
- Snoops byte writes to the memory-mapped I/O window, buffers output characters, and drains them to a bench-side character sink over valid/ready.
- Detects the program-halt write and asserts done only after all buffered characters are drained; reports exit code and cycle count.

Parameters:
- FIFO_DEPTH_LOG, 4, log2 of character FIFO depth (16 entries)
- ADDR_W, 32, bus address width
- IO_CHAR_ADDR, 32'h00030000, write here = output character
- IO_HALT_ADDR, 32'h00030004, write here = halt; data byte = exit code

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global enable; when low, no bus sampling and no state change except the sink handshake
- mem_a  input  ADDR_W  CPU bus address
- mem_dout  input  8  CPU write data byte
- mem_wr  input  1  CPU write strobe (1 = write)
- char_valid  output  1  character available to sink
- char_data  output  8  character byte
- char_ready  input  1  sink accepts when valid&ready
- done  output  1  program halted and FIFO drained (sticky)
- exit_code  output  8  halt data byte
- cycle_count  output  32  rdy_in cycles from reset release to halt
- overflow  output  1  sticky: a character was dropped on full FIFO

Behaviour:
- Clock is clk_in; reset is synchronous and active-high on rst_in. Reset clears the FIFO, the state, and all outputs: char_valid=0, char_data=0, done=0, exit_code=0, cycle_count=0, overflow=0.
- A bus event is mem_wr & rdy_in with an exact address match. All other addresses are ignored, as are reads and writes while rdy_in=0.
- Char write: push mem_dout at the next edge, so it is visible on char_valid 1 cycle later (FIFO is first-word-fall-through: char_data = head whenever char_valid=1).
- Full FIFO with a simultaneous pop: the push is accepted. Full with no pop: the byte is dropped and overflow is set (sticky).
- Pop occurs on char_valid & char_ready, independent of rdy_in.
- Empty FIFO: char_valid=0, and char_data holds its last value.
- Pointers are FIFO_DEPTH_LOG+1 bits wide with a wrap bit; full/empty are derived from pointer equality.
- States:
  - RUN: cycle_count increments per rdy_in cycle and saturates at 32'hFFFFFFFF. A halt write latches exit_code and moves to DRAIN.
  - DRAIN: counter frozen; bus ignored, so later char writes are dropped without setting overflow. When the FIFO is empty, move to DONE.
  - DONE: done=1; terminal until rst_in.
- A halt write when the FIFO is already empty gives done=1 two edges after the write edge (RUN->DRAIN->DONE).
- Char and halt writes are never simultaneous (single bus).
- rst_in mid-DRAIN discards pending characters and returns to RUN.

Optional Feature:
- Macro: IO_MONITOR_TIMEOUT_EN.
- When defined:
  - adds parameter TIMEOUT_CYCLES (default 32'd50_000_000) and output timeout (1, sticky).
  - If cycle_count reaches TIMEOUT_CYCLES in RUN, set timeout=1, exit_code=8'hFF, and go to DRAIN.
- When undefined: no timeout port, and no comparator logic.

Decomposition:
- Shared package io_monitor_pkg: IO_CHAR_ADDR/IO_HALT_ADDR defaults, state enum type (RUN, DRAIN, DONE), 8-bit byte typedef, exit code constant for timeout (8'hFF).
- One sub-module: io_char_fifo (parameterised synchronous FWFT FIFO with push/pop/full/empty), instantiated once.

Test Plan:
- Reset: hold rst_in=1 for 25 cycles, then write 0x41 to IO_CHAR_ADDR -> all outputs 0 during reset; char_valid=1 with char_data=8'h41 exactly 1 cycle after the write edge.
- Ordered drain with backpressure: write "HI\n" (0x48,0x49,0x0A) with char_ready=0, then raise char_ready -> bytes are popped in order, one per cycle; overflow=0.
- Overflow: 17 char writes with char_ready=0 at depth 16 -> 16 bytes retained, 17th dropped, overflow=1. Push on a full FIFO with a simultaneous pop -> accepted, overflow unchanged.
- Halt with pending data: 3 chars buffered, then write 8'h00 to IO_HALT_ADDR -> done stays 0 until the 3rd pop, asserts on the following cycle; exit_code=0; cycle_count frozen; a char write after halt is dropped with overflow=0.
- rdy_in gating: writes while rdy_in=0 -> ignored, cycle_count not incremented. Write to 32'h00030008 -> ignored.
- With IO_MONITOR_TIMEOUT_EN and TIMEOUT_CYCLES=100: no halt write -> timeout=1 and exit_code=8'hFF at count 100, then done=1 once the FIFO drains.
